// File: rtl/nr_sqrt_reconstruct.sv
// nr_sqrt_reconstruct: rebuilds radicand = root*root + remainder from a
// non-restoring sqrt result using an iterative shift-add squarer, one root
// bit per enabled clock.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   clk_en_i     clock enable; low freezes every register
//   start_i      request, sampled only in IDLE
//   root_i       root operand (OUT_WIDTH bits)
//   remainder_i  remainder operand (OUT_WIDTH+1 bits)
//   radicand_o   reconstructed radicand, held until next result
//   valid_o      one-enabled-cycle result strobe
//   busy_o       high while SQUARE or DONE
//   error_o      remainder exceeded 2*root at accept
//   overflow_o   true sum did not fit DATA_WIDTH bits
module nr_sqrt_reconstruct #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH / 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  start_i,
  input  logic [OUT_WIDTH-1:0]  root_i,
  input  logic [OUT_WIDTH:0]    remainder_i,
  output logic [DATA_WIDTH-1:0] radicand_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic                  overflow_o
);

  localparam int unsigned ACC_W = DATA_WIDTH + 1;
  localparam int unsigned CNT_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   mplier_q, mplier_d;
  logic [OUT_WIDTH-1:0]   mcand_q, mcand_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   err_flag_q, err_flag_d;
  logic [DATA_WIDTH-1:0]  radicand_q, radicand_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   error_q, error_d;
  logic                   overflow_q, overflow_d;

  // State and datapath registers; clk_en_i low holds everything.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mplier_q   <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      err_flag_q <= 1'b0;
      radicand_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clk_en_i) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mplier_q   <= mplier_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      err_flag_q <= err_flag_d;
      radicand_q <= radicand_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mplier_d   = mplier_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    err_flag_d = err_flag_q;
    radicand_d = radicand_q;
    valid_d    = 1'b0;
    error_d    = error_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mplier_d   = root_i;
          mcand_d    = root_i;
          acc_d      = ACC_W'(remainder_i);
          cnt_d      = '0;
          err_flag_d = (remainder_i > {root_i, 1'b0});
          state_d    = SQUARE;
        end
      end
      SQUARE: begin
        // Accumulator is one bit wider than the radicand so the sum never wraps.
        if (mplier_q[cnt_q]) begin
          acc_d = acc_q + (ACC_W'(mcand_q) << cnt_q);
        end
        if (cnt_q == CNT_W'(OUT_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        radicand_d = acc_q[DATA_WIDTH-1:0];
        overflow_d = acc_q[DATA_WIDTH];
        error_d    = err_flag_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign radicand_o = radicand_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign error_o    = error_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_nr_sqrt_reconstruct.sv
// Self-checking bench for nr_sqrt_reconstruct: scoreboard of expected
// results from an arithmetic reference model, with a separate monitor.
module tb_nr_sqrt_reconstruct;

  localparam int unsigned DW = 48;
  localparam int unsigned OW = 24;
  localparam int unsigned RW = OW + 1;

  typedef struct packed {
    logic [DW-1:0] rad;
    logic          err;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic          start = 1'b0;
  logic [OW-1:0] root = '0;
  logic [RW-1:0] rem = '0;
  logic [DW-1:0] radicand;
  logic          valid;
  logic          busy;
  logic          error;
  logic          overflow;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  logic valid_prev = 1'b0;

  nr_sqrt_reconstruct #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clk_en_i   (clk_en),
    .start_i    (start),
    .root_i     (root),
    .remainder_i(rem),
    .radicand_o (radicand),
    .valid_o    (valid),
    .busy_o     (busy),
    .error_o    (error),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [OW-1:0] r, input logic [RW-1:0] m);
    logic [63:0] s;
    exp_t e;
    s     = 64'(r) * 64'(r) + 64'(m);
    e.rad = s[DW-1:0];
    e.ovf = s[DW];
    e.err = (64'(m) > 64'(r) * 64'd2);
    return e;
  endfunction

  // Monitor: compare each result strobe against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid && !valid_prev) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid actual=1 required=0 radicand=%0h", radicand);
      end else begin
        e = sb.pop_front();
        check("radicand", 64'(radicand), 64'(e.rad));
        check("error", 64'(error), 64'(e.err));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
    valid_prev = valid;
  end

  task automatic run_op(input logic [OW-1:0] r, input logic [RW-1:0] m,
                        input int gap_at, input int gap_len, input int extra_at,
                        input int exp_lat);
    int n;
    bit busy_ok;
    bit got;
    @(negedge clk);
    root = r; rem = m; start = 1'b1;
    sb.push_back(model(r, m));
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_ok = 1'b1; got = 1'b0;
    while (!got && n < 200) begin
      if (n == 1) begin root = OW'($urandom); rem = RW'($urandom); end
      if (gap_len > 0 && n == gap_at) clk_en = 1'b0;
      if (gap_len > 0 && n == gap_at + gap_len) clk_en = 1'b1;
      if (extra_at > 0 && n == extra_at) begin start = 1'b1; root = OW'(7); rem = RW'(3); end
      if (extra_at > 0 && n == extra_at + 1) start = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    clk_en = 1'b1;
    start  = 1'b0;
    if (!got) begin
      total_cnt++;
      $display("FAIL latency_timeout actual=%0d required=%0d", n, exp_lat);
    end else begin
      check("latency", 64'(n), 64'(exp_lat));
      check("busy_during_op", 64'(busy_ok), 64'd1);
      check("busy_low_at_valid", 64'(busy), 64'd0);
      @(negedge clk);
      check("valid_one_cycle", 64'(valid), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_radicand"}, 64'(radicand), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    int t[3];
    int k;
    int cyc;
    logic [OW-1:0] r;
    logic [RW-1:0] m;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed corner pairs.
    run_op(24'd0, 25'd0, 0, 0, 0, 25);
    run_op(24'hB504F3, 25'd4817239, 0, 0, 0, 25);
    check("sqrt2_const", 64'(radicand), 64'h8000_0000_0000);
    run_op(24'hFFFFFF, 25'h1FFFFFE, 0, 0, 0, 25);
    check("max_legal_const", 64'(radicand), 64'hFFFF_FFFF_FFFF);
    run_op(24'hFFFFFF, 25'h1FFFFFF, 0, 0, 0, 25);
    check("illegal_err_const", 64'(error), 64'd1);
    check("illegal_ovf_const", 64'(overflow), 64'd1);

    // Asynchronous reset mid-SQUARE discards the operation.
    @(negedge clk);
    root = 24'h123456; rem = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_valid_after_reset", 64'(valid), 64'd0);
    run_op(24'd5, 25'd2, 0, 0, 0, 25);

    // Clock-enable gap plus an ignored start while busy.
    run_op(24'd3, 25'd1, 8, 5, 16, 30);

    // Back-to-back with start held high.
    @(negedge clk);
    root = 24'd2; rem = 25'd0; start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(24'd2, 25'd0));
    k = 0; cyc = 0;
    while (k < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (valid) begin t[k] = cyc; k++; end
    end
    start = 1'b0;
    if (k < 3) begin
      total_cnt++;
      $display("FAIL b2b_timeout actual=%0d required=3", k);
    end else begin
      check("b2b_spacing_1", 64'(t[1] - t[0]), 64'd26);
      check("b2b_spacing_2", 64'(t[2] - t[1]), 64'd26);
    end
    repeat (30) @(negedge clk);

    // Randomized operands, mixing legal and arbitrary remainders.
    for (int i = 0; i < 16; i++) begin
      r = OW'($urandom);
      if (i % 2 == 0) m = RW'($urandom_range(0, 2 * int'(r)));
      else            m = RW'($urandom);
      run_op(r, m, 0, 0, 0, 25);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
